// File: rtl/freq_pkg.sv
// freq_pkg: shared range codes, gate FSM states and display helpers for the frequency counter front end
package freq_pkg;
  localparam logic [1:0] RANGE_1S    = 2'b00;
  localparam logic [1:0] RANGE_100MS = 2'b01;
  localparam logic [1:0] RANGE_10S   = 2'b10;
  localparam logic [1:0] DP_NONE     = 2'b00;
  localparam logic [1:0] DP_ONE      = 2'b01;
  localparam logic [1:0] DP_TENTHS   = 2'b10;
  typedef enum logic [1:0] {IDLE, FLUSH, GATE} state_t;
  function automatic logic [1:0] norm_range(input logic [1:0] r);
    return r == 2'b11 ? RANGE_1S : r;
  endfunction
  function automatic logic [31:0] window_len(input logic [1:0] r, input logic [31:0] hz);
    return r == RANGE_100MS ? hz / 32'd10 : r == RANGE_10S ? hz * 32'd10 : hz;
  endfunction
  function automatic logic [1:0] dp_code(input logic [1:0] r);
    return r == RANGE_100MS ? DP_TENTHS : r == RANGE_10S ? DP_ONE : DP_NONE;
  endfunction
endpackage

// File: rtl/sig_conditioner.sv
// sig_conditioner: synchronizes sig_in, rejects short glitches and flags each filtered rising edge
module sig_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 2
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic sig_in,
  output logic pulse
);
  localparam int CW = $clog2(GLITCH_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic filt, filt_q, s;
  assign s = sync[SYNC_STAGES-1];
  assign pulse = filt & ~filt_q;
  // cnt tracks how many consecutive samples have disagreed with the filtered level
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      sync   <= '0;
      cnt    <= '0;
      filt   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], sig_in};
      filt_q <= filt;
      if (s == filt) cnt <= '0;
      else if (cnt == CW'(GLITCH_CYCLES - 1)) begin
        filt <= s;
        cnt  <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/freq_gate_timebase.sv
// freq_gate_timebase: gate-time FSM producing the oneHz latch/clear strobe and the conditioned testSignal pulses
module freq_gate_timebase
  import freq_pkg::*;
#(
  parameter int CLK_HZ        = 50000000,
  parameter int SYNC_STAGES   = 2,
  parameter int GLITCH_CYCLES = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       sig_in,
  input  logic       enable,
  input  logic [1:0] range_sel,
  output logic       oneHz,
  output logic       testSignal,
  output logic       gate_active,
  output logic       meas_valid,
  output logic [1:0] dp_pos
);
  state_t state;
  logic pulse, en_q, pend, chg, strobe_nxt;
  logic [1:0] range_q, rng;
  logic [31:0] cnt, n_len;
  sig_conditioner #(.SYNC_STAGES(SYNC_STAGES), .GLITCH_CYCLES(GLITCH_CYCLES)) u_cond (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .sig_in(sig_in),
    .pulse(pulse)
  );
  assign rng   = norm_range(range_sel);
  assign n_len = window_len(rng, 32'(CLK_HZ));
  assign chg   = rng != range_q;
  // strobe is registered, so it is decided one cycle ahead: it lands on the cycle where cnt == 0
  assign strobe_nxt = enable && (state == IDLE ? !en_q : state == GATE && (chg || cnt == 32'd1));
  always_ff @(posedge CLOCK_50 or negedge reset)
    if (!reset) begin
      state       <= IDLE;
      en_q        <= 1'b0;
      range_q     <= RANGE_1S;
      cnt         <= '0;
      pend        <= 1'b0;
      oneHz       <= 1'b0;
      testSignal  <= 1'b0;
      gate_active <= 1'b0;
      meas_valid  <= 1'b0;
      dp_pos      <= DP_NONE;
    end else begin
      en_q    <= enable;
      range_q <= rng;
      dp_pos  <= dp_code(rng);
      oneHz   <= strobe_nxt;
      if (!enable) begin
        state       <= IDLE;
        gate_active <= 1'b0;
        meas_valid  <= 1'b0;
        testSignal  <= 1'b0;
        pend        <= 1'b0;
      end else begin
        case (state)
          IDLE: if (!en_q) begin
            state      <= FLUSH;
            meas_valid <= 1'b0;
          end
          FLUSH: begin
            state       <= GATE;
            gate_active <= 1'b1;
            cnt         <= n_len - 32'd1;
          end
          default: if (chg) begin
            state       <= FLUSH;
            gate_active <= 1'b0;
            meas_valid  <= 1'b0;
          end else begin
            cnt <= cnt == 32'd0 ? n_len - 32'd1 : cnt - 32'd1;
            if (cnt == 32'd1) meas_valid <= 1'b1;
          end
        endcase
        // an edge colliding with a strobe is held one cycle so it counts in the new window
        testSignal <= state != IDLE && !strobe_nxt && (pulse || pend);
        pend       <= state != IDLE && strobe_nxt && pulse;
      end
    end
endmodule
